// File: rtl/cardinal_router_node_buf_if.sv
// Five-port mesh router link bundle: valid/data/ready per input and per output, plus phase bit.
interface cardinal_router_node_buf_if #(
   parameter int DATA_W = 64
);
   logic              n_si, s_si, e_si, w_si, pe_si;
   logic [DATA_W-1:0] n_di, s_di, e_di, w_di, pe_di;
   logic              n_ri, s_ri, e_ri, w_ri, pe_ri;
   logic              n_so, s_so, e_so, w_so, pe_so;
   logic [DATA_W-1:0] n_do, s_do, e_do, w_do, pe_do;
   logic              n_ro, s_ro, e_ro, w_ro, pe_ro;
   logic              polarity;

   modport master (
      output n_si, s_si, e_si, w_si, pe_si,
      output n_di, s_di, e_di, w_di, pe_di,
      output n_ro, s_ro, e_ro, w_ro, pe_ro,
      input  n_ri, s_ri, e_ri, w_ri, pe_ri,
      input  n_so, s_so, e_so, w_so, pe_so,
      input  n_do, s_do, e_do, w_do, pe_do,
      input  polarity
   );

   modport slave (
      input  n_si, s_si, e_si, w_si, pe_si,
      input  n_di, s_di, e_di, w_di, pe_di,
      input  n_ro, s_ro, e_ro, w_ro, pe_ro,
      output n_ri, s_ri, e_ri, w_ri, pe_ri,
      output n_so, s_so, e_so, w_so, pe_so,
      output n_do, s_do, e_do, w_do, pe_do,
      output polarity
   );
endinterface

// File: rtl/cardinal_router_node_buf.sv
// Input-buffered XY mesh router node: per-input FIFO, per-output round-robin arbiter and
// one-entry output register. Port index order everywhere is n, s, e, w, pe.
module cardinal_router_node_buf #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int HOP_W  = 4
) (
   input logic                       clk,
   input logic                       reset,
   cardinal_router_node_buf_if.slave bus
);
   localparam int NP = 5;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HX = DATA_W - 3;
   localparam int HY = DATA_W - 3 - HOP_W;
   localparam logic [2:0] P_N = 3'd0, P_S = 3'd1, P_E = 3'd2, P_W = 3'd3, P_PE = 3'd4;
   localparam logic [HOP_W-1:0] HOP_ONE = HOP_W'(1);

   logic [NP-1:0]     w_si, w_ri, w_ro, w_push, w_pop, w_hvld, w_gvld;
   logic [DATA_W-1:0] w_di   [NP];
   logic [DATA_W-1:0] w_head [NP];
   logic [DATA_W-1:0] w_fwd  [NP];
   logic [2:0]        w_dst  [NP];
   logic [2:0]        w_gsel [NP];

   logic [DATA_W-1:0] r_mem [NP][DEPTH];
   logic [AW-1:0]     r_wp  [NP];
   logic [AW-1:0]     r_rp  [NP];
   logic [CW-1:0]     r_cnt [NP];
   logic [NP-1:0]     r_so;
   logic [DATA_W-1:0] r_do  [NP];
   logic [2:0]        r_ptr [NP];
   logic              r_pol;

   assign w_si = {bus.pe_si, bus.w_si, bus.e_si, bus.s_si, bus.n_si};
   assign w_ro = {bus.pe_ro, bus.w_ro, bus.e_ro, bus.s_ro, bus.n_ro};
   assign w_di[0] = bus.n_di;
   assign w_di[1] = bus.s_di;
   assign w_di[2] = bus.e_di;
   assign w_di[3] = bus.w_di;
   assign w_di[4] = bus.pe_di;

   assign {bus.pe_ri, bus.w_ri, bus.e_ri, bus.s_ri, bus.n_ri} = w_ri;
   assign {bus.pe_so, bus.w_so, bus.e_so, bus.s_so, bus.n_so} = r_so;
   assign bus.n_do     = r_do[0];
   assign bus.s_do     = r_do[1];
   assign bus.e_do     = r_do[2];
   assign bus.w_do     = r_do[3];
   assign bus.pe_do    = r_do[4];
   assign bus.polarity = r_pol;

   for (genvar i = 0; i < NP; i++) begin : g_in
      // Full FIFO refuses a flit even when it pops that cycle.
      assign w_ri[i]   = r_cnt[i] < CW'(DEPTH);
      assign w_push[i] = w_si[i] & w_ri[i];
      assign w_hvld[i] = r_cnt[i] != '0;
      assign w_head[i] = r_mem[i][r_rp[i]];
   end

   // Strict XY route of each head and the hop-decremented copy that gets forwarded.
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         w_fwd[i] = w_head[i];
         w_dst[i] = P_PE;
         if (w_head[i][HX -: HOP_W] != '0) begin
            w_dst[i] = w_head[i][DATA_W-1] ? P_W : P_E;
            w_fwd[i][HX -: HOP_W] = w_head[i][HX -: HOP_W] - HOP_ONE;
         end else if (w_head[i][HY -: HOP_W] != '0) begin
            w_dst[i] = w_head[i][DATA_W-2] ? P_S : P_N;
            w_fwd[i][HY -: HOP_W] = w_head[i][HY -: HOP_W] - HOP_ONE;
         end
      end
   end

   always_comb begin
      int j;
      j      = 0;
      w_gvld = '0;
      w_pop  = '0;
      for (int o = 0; o < NP; o++) begin
         w_gsel[o] = '0;
         if (!r_so[o] || w_ro[o]) begin
            for (int k = 0; k < NP; k++) begin
               j = int'(r_ptr[o]) + k;
               if (j >= NP) j = j - NP;
               if (!w_gvld[o] && w_hvld[j] && w_dst[j] == 3'(o)) begin
                  w_gvld[o] = 1'b1;
                  w_gsel[o] = 3'(j);
                  w_pop[j]  = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NP; i++)
         if (w_push[i]) r_mem[i][r_wp[i]] <= w_di[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pol <= 1'b0;
         r_so  <= '0;
         for (int i = 0; i < NP; i++) begin
            r_wp[i]  <= '0;
            r_rp[i]  <= '0;
            r_cnt[i] <= '0;
            r_do[i]  <= '0;
            r_ptr[i] <= P_N;
         end
      end else begin
         r_pol <= ~r_pol;
         for (int i = 0; i < NP; i++) begin
            if (w_push[i]) r_wp[i] <= r_wp[i] + AW'(1);
            if (w_pop[i])  r_rp[i] <= r_rp[i] + AW'(1);
            r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
         end
         for (int o = 0; o < NP; o++) begin
            if (w_gvld[o]) begin
               r_so[o]  <= 1'b1;
               r_do[o]  <= w_fwd[w_gsel[o]];
               r_ptr[o] <= (w_gsel[o] == P_PE) ? P_N : w_gsel[o] + 3'd1;
            end else if (w_ro[o]) begin
               r_so[o] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_cardinal_router_node_buf.sv
// Directed bench for cardinal_router_node_buf: routing table plus backpressure,
// round-robin contention and mid-operation reset sequences.
module tb_cardinal_router_node_buf;
   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_err    = 0;

   cardinal_router_node_buf_if #(.DATA_W(64)) bus();

   cardinal_router_node_buf #(.DATA_W(64), .DEPTH(4), .HOP_W(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   typedef struct {
      string       nm;
      int          src;
      logic [63:0] din;
      int          dst;
      logic [63:0] dexp;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input int p, input logic v, input logic [63:0] d);
      case (p)
         0: begin bus.n_si  = v; bus.n_di  = d; end
         1: begin bus.s_si  = v; bus.s_di  = d; end
         2: begin bus.e_si  = v; bus.e_di  = d; end
         3: begin bus.w_si  = v; bus.w_di  = d; end
         default: begin bus.pe_si = v; bus.pe_di = d; end
      endcase
   endtask

   task automatic set_ro(input logic [4:0] r);
      {bus.pe_ro, bus.w_ro, bus.e_ro, bus.s_ro, bus.n_ro} = r;
   endtask

   function automatic logic [4:0] so_vec();
      return {bus.pe_so, bus.w_so, bus.e_so, bus.s_so, bus.n_so};
   endfunction

   function automatic logic [4:0] ri_vec();
      return {bus.pe_ri, bus.w_ri, bus.e_ri, bus.s_ri, bus.n_ri};
   endfunction

   function automatic logic [63:0] do_of(input int q);
      case (q)
         0: return bus.n_do;
         1: return bus.s_do;
         2: return bus.e_do;
         3: return bus.w_do;
         default: return bus.pe_do;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"pe_east",    4, 64'h0800_0000_0000_00AB, 2, 64'h0400_0000_0000_00AB};
      vecs[1] = '{"w_eject",    3, 64'h0000_0000_0000_1234, 4, 64'h0000_0000_0000_1234};
      vecs[2] = '{"n_west",     0, 64'h8400_0000_0000_0001, 3, 64'h8000_0000_0000_0001};
      vecs[3] = '{"e_north",    2, 64'h00C0_0000_0000_0055, 0, 64'h0080_0000_0000_0055};
      vecs[4] = '{"s_south",    1, 64'h4040_0000_0000_00FF, 1, 64'h4000_0000_0000_00FF};
      vecs[5] = '{"pe_eject",   4, 64'hC000_0000_DEAD_BEEF, 4, 64'hC000_0000_DEAD_BEEF};
      vecs[6] = '{"n_x_first",  0, 64'h3D40_0000_0000_0007, 2, 64'h3940_0000_0000_0007};

      for (int p = 0; p < 5; p++) set_in(p, 1'b0, 64'h0);
      set_ro(5'b11111);
      reset = 1'b1;
      #3;
      chk("rst_so", 64'(so_vec()), 64'h0);
      chk("rst_ri", 64'(ri_vec()), 64'h1F);
      chk("rst_pol", 64'(bus.polarity), 64'h0);
      chk("rst_edo", do_of(2), 64'h0);
      step();
      reset = 1'b0;
      step(); chk("pol_1", 64'(bus.polarity), 64'h1);
      step(); chk("pol_2", 64'(bus.polarity), 64'h0);
      step(); chk("pol_3", 64'(bus.polarity), 64'h1);

      // Single-flit routing table: accept at edge t, output valid after t+1, gone after t+2.
      for (int v = 0; v < 7; v++) begin
         set_in(vecs[v].src, 1'b1, vecs[v].din);
         step();
         set_in(vecs[v].src, 1'b0, 64'h0);
         step();
         chk({vecs[v].nm, "_so"}, 64'(so_vec()), 64'(5'b1 << vecs[v].dst));
         chk({vecs[v].nm, "_do"}, do_of(vecs[v].dst), vecs[v].dexp);
         step();
         chk({vecs[v].nm, "_drain"}, 64'(so_vec()), 64'h0);
      end

      // Backpressure on east: five flits from w, one held in the register, four buffered.
      set_ro(5'b11011);
      for (int k = 1; k <= 5; k++) begin
         chk("bp_ri_before", 64'(bus.w_ri), 64'h1);
         set_in(3, 1'b1, 64'h0400_0000_0000_0000 | 64'(k));
         step();
      end
      chk("bp_full_ri", 64'(bus.w_ri), 64'h0);
      chk("bp_hold_so", 64'(bus.e_so), 64'h1);
      chk("bp_hold_do", bus.e_do, 64'h1);
      step();
      chk("bp_stall_do", bus.e_do, 64'h1);
      chk("bp_stall_ri", 64'(bus.w_ri), 64'h0);
      set_in(3, 1'b1, 64'h0400_0000_0000_0066);
      set_ro(5'b11111);
      for (int k = 2; k <= 5; k++) begin
         step();
         if (k == 2) begin
            set_in(3, 1'b0, 64'h0);
            chk("bp_ri_after_pop", 64'(bus.w_ri), 64'h1);
         end
         chk("bp_drain_so", 64'(bus.e_so), 64'h1);
         chk("bp_drain_do", bus.e_do, 64'(k));
      end
      step();
      chk("bp_end_so", 64'(so_vec()), 64'h0);

      // Round-robin contention on east between n and s.
      do_reset();
      set_in(0, 1'b1, 64'h0400_0000_0000_00A1);
      set_in(1, 1'b1, 64'h0400_0000_0000_00B1);
      step();
      set_in(0, 1'b0, 64'h0);
      set_in(1, 1'b0, 64'h0);
      step(); chk("rr1_first", bus.e_do, 64'hA1);
      step(); chk("rr1_second", bus.e_do, 64'hB1);
      set_in(0, 1'b1, 64'h0400_0000_0000_00C1);
      step();
      set_in(0, 1'b0, 64'h0);
      step(); chk("rr_lone_n", bus.e_do, 64'hC1);
      set_in(0, 1'b1, 64'h0400_0000_0000_00D1);
      set_in(1, 1'b1, 64'h0400_0000_0000_00E1);
      step();
      set_in(0, 1'b0, 64'h0);
      set_in(1, 1'b0, 64'h0);
      step(); chk("rr2_first_s", bus.e_do, 64'hE1);
      step(); chk("rr2_second_n", bus.e_do, 64'hD1);
      step(); chk("rr_end_so", 64'(so_vec()), 64'h0);

      // Reset while east holds a flit and w still buffers three.
      set_ro(5'b11011);
      for (int k = 1; k <= 4; k++) begin
         set_in(3, 1'b1, 64'h0400_0000_0000_0010 | 64'(k));
         step();
      end
      set_in(3, 1'b0, 64'h0);
      chk("mr_pre_so", 64'(bus.e_so), 64'h1);
      chk("mr_pre_do", bus.e_do, 64'h11);
      #2;
      reset = 1'b1;
      #1;
      chk("mr_async_so", 64'(so_vec()), 64'h0);
      chk("mr_async_do", bus.e_do, 64'h0);
      chk("mr_async_ri", 64'(ri_vec()), 64'h1F);
      chk("mr_async_pol", 64'(bus.polarity), 64'h0);
      step();
      reset = 1'b0;
      set_ro(5'b11111);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("mr_no_stale", 64'(so_vec()), 64'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
